// File: rtl/systolic_array_cell.sv
// Weight-stationary systolic PE: holds one signed weight and produces
// a registered multiply-accumulate of the upstream partial sum.
module systolic_array_cell #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           param_load,
  input  logic signed [DATA_WIDTH-1:0]   input_data,
  input  logic signed [2*DATA_WIDTH-1:0] prop_data,
  input  logic signed [DATA_WIDTH-1:0]   param_data,
  output logic signed [2*DATA_WIDTH-1:0] out_data,
  output logic signed [DATA_WIDTH-1:0]   prop_param
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [DATA_WIDTH-1:0] weight;
  logic signed [PW-1:0]         result;
  logic signed [PW-1:0]         product;
  logic signed [PW-1:0]         mac;

  // Operands widen to PW before multiply so the product is full precision.
  always_comb begin
    product = PW'(input_data) * PW'(weight);
    mac     = prop_data + product;
  end

  // reset_n is active-high despite its name.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      weight <= '0;
      result <= '0;
    end else if (param_load) begin
      weight <= param_data;
    end else begin
      result <= mac;
    end
  end

  assign out_data   = result;
  assign prop_param = weight;

endmodule

// File: tb/tb_systolic_array_cell.sv
// Self-checking bench for systolic_array_cell with an integer model
// and directed vectors.
module tb_systolic_array_cell;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               param_load;
  logic signed [7:0]  input_data;
  logic signed [15:0] prop_data;
  logic signed [7:0]  param_data;
  logic signed [15:0] out_data;
  logic signed [7:0]  prop_param;

  int n_cmp = 0;
  int n_bad = 0;
  bit run = 1'b0;

  int exp_w = 0;
  int exp_r = 0;

  always #5 clk = ~clk;

  systolic_array_cell #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .param_load (param_load),
    .input_data (input_data),
    .prop_data  (prop_data),
    .param_data (param_data),
    .out_data   (out_data),
    .prop_param (prop_param)
  );

  function automatic int wrap16(int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic int wrap8(int v);
    logic signed [7:0] t;
    t = v[7:0];
    return int'(t);
  endfunction

  task automatic chk(string nm, int act, int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("cyc_out", int'(out_data), exp_r);
      chk("cyc_prm", int'(prop_param), exp_w);
    end
  end

  // One clock edge; the model applies the behavioural rule at the edge.
  task automatic step(bit ld, int pd, int in, int pr);
    param_load = ld;
    param_data = 8'(pd);
    input_data = 8'(in);
    prop_data  = 16'(pr);
    @(posedge clk);
    if (!reset_n) begin
      if (ld) exp_w = wrap8(pd);
      else exp_r = wrap16(pr + wrap8(in) * exp_w);
    end
    #1;
  endtask

  initial begin
    reset_n    = 1'b1;
    param_load = 1'b0;
    param_data = 8'($urandom);
    input_data = 8'($urandom);
    prop_data  = 16'sd2;
    #2;
    chk("rst_async_out", int'(out_data), 0);
    chk("rst_async_prm", int'(prop_param), 0);
    run = 1'b1;
    step(1'b0, 3, 7, 2);
    step(1'b1, 9, 4, 2);
    chk("rst_held_out", int'(out_data), 0);
    chk("rst_held_prm", int'(prop_param), 0);
    reset_n = 1'b0;

    step(1'b1, 5, 0, 0);
    chk("load5_prm", int'(prop_param), 5);
    chk("load5_out", int'(out_data), 0);

    step(1'b0, 0, 1, 2);
    chk("mac7", int'(out_data), 7);
    step(1'b0, 0, 5, 2);
    chk("mac27", int'(out_data), 27);
    step(1'b0, 0, -3, 2);
    chk("mac_neg13", int'(out_data), -13);

    step(1'b1, -128, 0, 0);
    chk("mac_neg13_hold", int'(out_data), -13);
    step(1'b0, 0, -128, 0);
    chk("mac_16384", int'(out_data), 16384);

    step(1'b1, 127, 0, 0);
    step(1'b0, 0, 127, 32767);
    chk("wrap", int'(out_data), -16640);

    step(1'b1, 5, 0, 0);
    step(1'b0, 0, 4, 1);
    chk("mac21", int'(out_data), 21);
    step(1'b1, -2, 9, 99);
    chk("reload_hold", int'(out_data), 21);
    chk("reload_prm", int'(prop_param), -2);
    step(1'b0, 0, 3, 10);
    chk("mac4", int'(out_data), 4);

    step(1'b1, 9, 0, 0);
    step(1'b1, -7, 0, 0);
    chk("b2b_prm", int'(prop_param), -7);
    step(1'b0, 0, 2, 100);
    chk("b2b_mac", int'(out_data), 86);

    for (int i = 0; i < 20; i++) begin
      step(1'(i % 5 == 0), $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 65535));
    end

    #2;
    param_load = 1'b1;
    param_data = 8'sd33;
    reset_n = 1'b1;
    exp_w = 0;
    exp_r = 0;
    #1;
    chk("rst_mid_out", int'(out_data), 0);
    chk("rst_mid_prm", int'(prop_param), 0);
    step(1'b1, 33, 1, 1);
    chk("rst_dom_prm", int'(prop_param), 0);
    reset_n = 1'b0;
    step(1'b0, 0, 6, 1);
    chk("post_rst_mac", int'(out_data), 1);
    step(1'b1, -1, 0, 0);
    step(1'b0, 0, 6, 1);
    chk("post_rst_mac2", int'(out_data), -5);

    @(negedge clk);
    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
